// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage resolves one CHUNK-bit slice and
// registers the carry. The result carries N/Z/C/V flags and the caller's tag.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAGW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v
);
    localparam int CHUNK = WIDTH / STAGES;

    // Registered state of each stage
    logic [STAGES-1:0] valid_q, carry_q, zero_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [TAGW-1:0]   tag_q [STAGES];
    logic              v_q;

    // What each stage sees at its input: the pipe entry for stage 0, the previous stage otherwise
    logic [STAGES-1:0] s_valid, s_carry, s_zero;
    logic [WIDTH-1:0]  s_a   [STAGES];
    logic [WIDTH-1:0]  s_b   [STAGES];
    logic [WIDTH-1:0]  s_sum [STAGES];
    logic [TAGW-1:0]   s_tag [STAGES];

    logic [STAGES-1:0] carry_d, zero_d;
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              v_d;
    logic              advance;

    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        // SUB/SBC invert B; ADD forces cin 0, SUB forces 1, ADC/SBC take in_cin.
        s_valid[0] = in_valid;
        s_a[0]     = in_a;
        s_b[0]     = in_op[0] ? ~in_b : in_b;
        s_carry[0] = in_op[1] ? in_cin : in_op[0];
        s_zero[0]  = 1'b1;
        s_sum[0]   = '0;
        s_tag[0]   = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            s_valid[k] = valid_q[k-1];
            s_a[k]     = a_q[k-1];
            s_b[k]     = b_q[k-1];
            s_carry[k] = carry_q[k-1];
            s_zero[k]  = zero_q[k-1];
            s_sum[k]   = sum_q[k-1];
            s_tag[k]   = tag_q[k-1];
        end
    end

    always_comb begin
        logic [CHUNK:0]   csum;
        logic [CHUNK-1:0] ca, cb;
        // NOTE: every comb output gets a default before the loop so no path leaves it unassigned (no latch).
        carry_d = '0;
        zero_d  = '0;
        v_d     = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            ca         = s_a[k][k*CHUNK +: CHUNK];
            cb         = s_b[k][k*CHUNK +: CHUNK];
            csum       = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, s_carry[k]};
            sum_d[k]   = s_sum[k];
            sum_d[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            carry_d[k] = csum[CHUNK];
            zero_d[k]  = s_zero[k] && (csum[CHUNK-1:0] == '0);
            // Carry into the chunk's top bit is recovered from its sum bit; the last stage's value is the one kept.
            v_d        = (csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1]) ^ csum[CHUNK];
        end
    end

    // NOTE: datapath registers are reset too, so outputs read zero during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            v_q     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= s_valid;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            v_q     <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= s_a[k];
                b_q[k]   <= s_b[k];
                sum_q[k] <= sum_d[k];
                tag_q[k] <= s_tag[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_n     = sum_q[STAGES-1][WIDTH-1];
    assign out_z     = zero_q[STAGES-1];
    assign out_c     = carry_q[STAGES-1];
    assign out_v     = v_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Drives three pipelined_addsub configurations (32/4, 64/8, 8/1) with shared stimulus
// and checks each against an arithmetic reference model with a per-DUT result queue.
module tb_pipelined_addsub;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11;
    localparam int WD  [3] = '{32, 64, 8};
    localparam int STG [3] = '{4, 8, 1};

    typedef struct packed {
        logic [63:0] sum;
        logic [3:0]  nzcv;
    } res_t;

    typedef struct {
        res_t       r;
        logic [3:0] tag;
        int         adv0;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_cin, out_ready;
    logic [63:0] in_a, in_b;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;

    logic [2:0]  iready, ovalid, fn, fz, fc, fv;
    logic [31:0] s32;
    logic [63:0] s64;
    logic [7:0]  s8;
    logic [3:0]  t32, t64, t8;

    ent_t q [3][$];
    int   adv [3];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAGW(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[0]),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ovalid[0]), .out_ready(out_ready), .out_sum(s32), .out_tag(t32),
        .out_n(fn[0]), .out_z(fz[0]), .out_c(fc[0]), .out_v(fv[0]));

    pipelined_addsub #(.WIDTH(64), .STAGES(8), .TAGW(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[1]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ovalid[1]), .out_ready(out_ready), .out_sum(s64), .out_tag(t64),
        .out_n(fn[1]), .out_z(fz[1]), .out_c(fc[1]), .out_v(fv[1]));

    pipelined_addsub #(.WIDTH(8), .STAGES(1), .TAGW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iready[2]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(ovalid[2]), .out_ready(out_ready), .out_sum(s8), .out_tag(t8),
        .out_n(fn[2]), .out_z(fz[2]), .out_c(fc[2]), .out_v(fv[2]));

    function automatic logic [63:0] get_sum(input int i);
        case (i)
            0:       return {32'd0, s32};
            1:       return s64;
            default: return {56'd0, s8};
        endcase
    endfunction

    function automatic logic [3:0] get_tag(input int i);
        case (i)
            0:       return t32;
            1:       return t64;
            default: return t8;
        endcase
    endfunction

    // Reference: plain w-bit arithmetic; V from operand/result signs rather than carries.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op, input logic cin, input int w);
        logic [63:0] mask, am, bm;
        logic [64:0] full;
        logic        ci, sa, sb, ss;
        res_t        r;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bm     = (op[0] ? ~b : b) & mask;
        ci     = op[1] ? cin : op[0];
        full   = {1'b0, am} + {1'b0, bm} + {64'd0, ci};
        r.sum  = full[63:0] & mask;
        sa     = am[w-1];
        sb     = bm[w-1];
        ss     = r.sum[w-1];
        r.nzcv = {ss, r.sum == 64'd0, full[w], (sa == sb) && (ss != sa)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle, entered at a falling edge: drive, predict, compare, push accepted ops.
    task automatic cycle(input bit v, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic cin, input logic [3:0] tag,
                         input bit rdy, output bit acc0);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_cin    = cin;
        in_tag    = tag;
        out_ready = rdy;
        acc0      = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            bit   ev, er;
            ent_t e;
            ev = (q[i].size() > 0) && (adv[i] - q[i][0].adv0 >= STG[i]);
            er = !ev || rdy;
            check($sformatf("d%0d.out_valid", i), {63'd0, ovalid[i]}, {63'd0, ev});
            check($sformatf("d%0d.in_ready", i), {63'd0, iready[i]}, {63'd0, er});
            if (ev && rdy) begin
                e = q[i].pop_front();
                check($sformatf("d%0d.sum", i), get_sum(i), e.r.sum);
                check($sformatf("d%0d.nzcv", i), {60'd0, fn[i], fz[i], fc[i], fv[i]}, {60'd0, e.r.nzcv});
                check($sformatf("d%0d.tag", i), {60'd0, get_tag(i)}, {60'd0, e.tag});
            end
            if (v && er) begin
                e.r    = model(a, b, op, cin, WD[i]);
                e.tag  = tag;
                e.adv0 = adv[i];
                q[i].push_back(e);
                if (i == 0) acc0 = 1'b1;
            end
            if (er) adv[i]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 64'd0, 64'd0, OP_ADD, 1'b0, 4'd0, 1'b1, acc);
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.d%0d.valid", tag, i), {63'd0, ovalid[i]}, 64'd0);
            check($sformatf("%s.d%0d.sum", tag, i), get_sum(i), 64'd0);
            check($sformatf("%s.d%0d.tag_flags", tag, i),
                  {56'd0, get_tag(i), fn[i], fz[i], fc[i], fv[i]}, 64'd0);
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = {64{1'b1}};
            2:       r = 64'h8000_0000_8000_0080;
            3:       r = 64'h7FFF_FFFF_7FFF_FF7F;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        bit acc;
        int t, c;
        for (int i = 0; i < 3; i++) adv[i] = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD; in_cin = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Directed vectors: overflow, zero, borrow, full carry chain, signed wrap, 8-bit corner
        cycle(1, 64'h7FFF_FFFF, 64'h1, OP_ADD, 1'b0, 4'h1, 1, acc);
        cycle(1, 64'h5, 64'h5, OP_SUB, 1'b0, 4'h2, 1, acc);
        cycle(1, 64'h0, 64'h1, OP_SUB, 1'b1, 4'h3, 1, acc);
        cycle(1, 64'hFFFF_FFFF, 64'h0, OP_ADC, 1'b1, 4'h4, 1, acc);
        cycle(1, 64'h8000_0000, 64'h1, OP_SBC, 1'b1, 4'h5, 1, acc);
        cycle(1, 64'h80, 64'h80, OP_ADD, 1'b0, 4'h6, 1, acc);
        cycle(1, {64{1'b1}}, 64'h0, OP_ADC, 1'b1, 4'h7, 1, acc);
        idle(12);

        // Eight back-to-back ops with out_ready held low for three cycles mid-stream
        t = 0;
        c = 0;
        while (t < 8 && c < 40) begin
            cycle(1, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), 1'($urandom),
                  4'(t), !(c >= 4 && c < 7), acc);
            if (acc) t++;
            c++;
        end
        check("stream.accepted", 64'(t), 64'd8);
        idle(12);
        for (int i = 0; i < 3; i++) check($sformatf("stream.d%0d.drained", i), 64'(q[i].size()), 64'd0);

        // Asynchronous reset with operations in flight
        repeat (3) cycle(1, rand_operand(), rand_operand(), OP_ADD, 1'b0, 4'hA, 1, acc);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) q[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        cycle(1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, OP_SUB, 1'b0, 4'hB, 1, acc);
        idle(10);

        // Randomised regression with random back-pressure
        repeat (600)
            cycle(1'($urandom_range(0, 3) != 0), rand_operand(), rand_operand(),
                  2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, acc);
        idle(14);
        for (int i = 0; i < 3; i++) check($sformatf("final.d%0d.drained", i), 64'(q[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined integer adder/subtractor with ADD/SUB/ADC/SBC modes and N/Z/C/V flags, for the MIPS datapath ALU and for multi-word arithmetic. The WIDTH-bit operation is split into STAGES equal chunks, with one chunk resolved and the carry registered per stage. This gives one result per cycle at a fixed latency. A valid/ready handshake on each side lets the execute stage stall the pipe without losing in-flight operations.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages; 1 ≤ STAGES ≤ WIDTH; CHUNK = WIDTH/STAGES.
- TAGW, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  pipe can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- in_cin  input  1  carry-in used by ADC/SBC only.
- in_tag  input  TAGW  returned unchanged with the result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_tag  output  TAGW  tag of this result.
- out_n, out_z, out_c, out_v  output  1 each  negative, zero, carry, signed overflow.

## Operation
- Effective B: in_b for ADD/ADC; ~in_b for SUB/SBC.
- Effective carry-in: ADD 0, SUB 1, ADC in_cin, SBC in_cin.
- Stage k (0-based) adds chunk k of A and effective B plus the carry registered by stage k−1 (stage 0 uses the effective carry-in).
  - Stage k registers: its chunk sum, carry-out, a zero-so-far bit, and the not-yet-consumed upper chunks of A/B.
- Result equals the full WIDTH-bit sum A + B_eff + cin, modulo 2^WIDTH.
- out_c = carry out of bit WIDTH−1. For SUB, C=1 means no borrow.
- out_v = carry into MSB XOR carry out of MSB.
- out_n = out_sum[WIDTH−1].
- out_z = 1 iff out_sum == 0, accumulated as the AND of per-chunk zero bits.
- Flags are computed for every op; ADC/SBC give a chained multi-word carry when in_cin is driven from the previous out_c.
- Per-stage valid bit. Global advance enable = !out_valid | out_ready.
  - All stages shift together when enabled.
  - Bubbles propagate as valid=0.
  - Pipe does not compact bubbles while stalled.
- in_ready = advance enable (combinational from out_valid/out_ready).
- Transfer occurs on an edge where valid & ready are both high, on either side.

## Timing
- Reset (rst_n low, asynchronous):
  - all valid bits 0, out_valid 0;
  - out_sum, out_tag and all flags 0;
  - in-flight operations discarded.
- Reset release: in_ready = 1 on the first cycle.
- Latency: an operation accepted at edge E presents out_valid=1 after edge E+STAGES−1, i.e. visible in the cycle after STAGES edges counting E. STAGES=1 gives registered output one edge after accept.
- Throughput: one op per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0;
  - all stage registers hold;
  - out_* stable until accepted.
- Simultaneous out accept and in accept in the same cycle is legal; no bubble is inserted.
- Ordering: results leave strictly in acceptance order, with tags intact.
- Inputs are ignored when in_valid=0 or in_ready=0; no X may propagate into valid bits.
- Reset asserted mid-operation: out_valid drops immediately (asynchronous); no pre-reset result is ever presented after release.

## Test plan
- Defaults: ADD 0x7FFFFFFF + 0x00000001.
  -> out_sum 0x80000000, N=1 Z=0 C=0 V=1.
  -> out_valid exactly 4 edges after accept; tag echoed.
- SUB 5 − 5 -> 0x00000000, Z=1 C=1 V=0 N=0.
- SUB 0 − 1 -> 0xFFFFFFFF, N=1 C=0 V=0.
- ADC 0xFFFFFFFF + 0 with cin=1.
  -> 0x00000000, C=1 Z=1; verifies the carry crossing all four chunk boundaries.
- SBC 0x80000000 − 1 with cin=1 -> 0x7FFFFFFF, V=1 C=1.
- 8 back-to-back ops (tags 0–7) with out_ready low for 3 cycles mid-stream.
  -> in_ready low exactly while stalled; all 8 results emerge in tag order, values correct, none duplicated or lost.
- 3 ops in flight, rst_n pulsed low mid-cycle.
  -> out_valid 0 immediately, outputs 0; after release no stale result appears; next op completes with normal latency.
- WIDTH=8, STAGES=1: ADD 0x80 + 0x80.
  -> 0x00, C=1 V=1 Z=1 N=0, latency 1 edge.
- Random regression against a reference model at WIDTH=32/STAGES=4 and WIDTH=64/STAGES=8.
